// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline hazard signal bundle between controller/datapath and hazard unit
interface hazard_unit_if;
   logic [4:0] rsD, rtD;
   logic [4:0] rsE, rtE;
   logic [4:0] writeregE, writeregM, writeregW;
   logic       regwriteE, regwriteM, regwriteW;
   logic       memtoregE, memtoregM;
   logic       branchD, bneD, jrD;
   logic       mdstartE;
   logic       mdreadD;
   logic       forwardaD, forwardbD;
   logic [1:0] forwardaE, forwardbE;
   logic       stallF, stallD;
   logic       flushE;
   logic       mdbusy;

   // Controller/datapath side: drives stage specifiers and control bits, consumes decisions
   modport master (
      output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
      output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
      output branchD, bneD, jrD, mdstartE, mdreadD,
      input  forwardaD, forwardbD, forwardaE, forwardbE,
      input  stallF, stallD, flushE, mdbusy
   );

   // Hazard unit side
   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
      input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
      input  branchD, bneD, jrD, mdstartE, mdreadD,
      output forwardaD, forwardbD, forwardaE, forwardbE,
      output stallF, stallD, flushE, mdbusy
   );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush and mult/div busy tracking (optional HAZARD_PERF_EN stall counter)
module hazard_unit #(
   parameter int MD_LATENCY = 4,
   parameter int MDW        = 4
) (
   input  logic             clk,
   input  logic             reset,
   hazard_unit_if.slave     hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]      stallcnt
`endif
);

   // Register $0 is hardwired, so it never creates a dependency
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   logic [MDW-1:0] md_cnt_q, md_cnt_d;
   logic           md_busy;
   logic           lwstall, branchstall, jrstall, mdstall, stall_any;
   logic [1:0]     fwd_a_e, fwd_b_e;
   logic           fwd_a_d, fwd_b_d;

   assign md_busy = (md_cnt_q != '0);

   // Next busy count: a new mult/div restarts the window, otherwise count down to idle
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (hz.mdstartE)
         md_cnt_d = MDW'(MD_LATENCY);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - 1'b1;
   end

   // Busy counter state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         md_cnt_q <= '0;
      else
         md_cnt_q <= md_cnt_d;
   end

   // Forwarding selects; Memory results are younger and win over Writeback
   always_comb begin
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;
      if (hz.regwriteM && reg_match(hz.rsE, hz.writeregM))
         fwd_a_e = 2'b10;
      else if (hz.regwriteW && reg_match(hz.rsE, hz.writeregW))
         fwd_a_e = 2'b01;
      if (hz.regwriteM && reg_match(hz.rtE, hz.writeregM))
         fwd_b_e = 2'b10;
      else if (hz.regwriteW && reg_match(hz.rtE, hz.writeregW))
         fwd_b_e = 2'b01;
      fwd_a_d = hz.regwriteM && reg_match(hz.rsD, hz.writeregM);
      fwd_b_d = hz.regwriteM && reg_match(hz.rtD, hz.writeregM);
   end

   // Stall sources, all OR-ed together with no priority
   always_comb begin
      lwstall     = hz.memtoregE &&
                    (reg_match(hz.rtE, hz.rsD) || reg_match(hz.rtE, hz.rtD));
      branchstall = (hz.branchD || hz.bneD) &&
                    ((hz.regwriteE && (reg_match(hz.writeregE, hz.rsD) ||
                                       reg_match(hz.writeregE, hz.rtD))) ||
                     (hz.memtoregM && (reg_match(hz.writeregM, hz.rsD) ||
                                       reg_match(hz.writeregM, hz.rtD))));
      jrstall     = hz.jrD &&
                    ((hz.regwriteE && reg_match(hz.writeregE, hz.rsD)) ||
                     (hz.memtoregM && reg_match(hz.writeregM, hz.rsD)));
      mdstall     = hz.mdreadD && (md_busy || hz.mdstartE);
      stall_any   = lwstall || branchstall || jrstall || mdstall;
   end

   // Drive outputs; everything is held low while reset is asserted
   always_comb begin
      hz.forwardaE = reset ? fwd_a_e : 2'b00;
      hz.forwardbE = reset ? fwd_b_e : 2'b00;
      hz.forwardaD = reset & fwd_a_d;
      hz.forwardbD = reset & fwd_b_d;
      hz.stallF    = reset & stall_any;
      hz.stallD    = reset & stall_any;
      hz.flushE    = reset & stall_any;
      hz.mdbusy    = reset & md_busy;
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stallcnt_q, stallcnt_d;

   // Saturating count of Decode stall cycles
   always_comb begin
      stallcnt_d = stallcnt_q;
      if (stall_any && (stallcnt_q != 32'hFFFF_FFFF))
         stallcnt_d = stallcnt_q + 32'd1;
   end

   // Stall counter state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stallcnt_q <= '0;
      else
         stallcnt_q <= stallcnt_d;
   end

   assign stallcnt = stallcnt_q;
`endif

endmodule
